// File: rtl/mult_signed_chain_pipe.sv
`timescale 1ns/1ps
// Pipelined chain of signed multipliers: each stage multiplies the signed halves of the
// previous product; the per-transaction tap select returns one stage's product.
module mult_signed_chain_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int IDW    = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     a,
    input  logic signed [WIDTH-1:0]     b,
    input  logic        [IDW-1:0]       id,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [2*WIDTH-1:0]   c,
    output logic [$clog2(STAGES+1)-1:0] occupancy
);
    localparam int PW  = 2 * WIDTH;
    localparam int OCW = $clog2(STAGES + 1);

    logic [STAGES-1:0] r_v;
    logic [PW-1:0]     r_p   [STAGES];
    logic [PW-1:0]     r_res [STAGES];
    logic [IDW-1:0]    r_sel [STAGES];
    logic [OCW-1:0]    r_occ;

    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_in_v;
    logic [STAGES-1:0] w_v_next;
    logic [PW-1:0]     w_prod    [STAGES];
    logic [PW-1:0]     w_res_new [STAGES];
    logic [IDW-1:0]    w_sel_src [STAGES];
    logic [IDW-1:0]    w_sel_in;
    logic [OCW-1:0]    w_occ_next;

    // Out-of-range tap selects collapse onto the last stage.
    always_comb begin
        if ({1'b0, id} > (IDW + 1)'(STAGES - 1)) begin
            w_sel_in = IDW'(STAGES - 1);
        end else begin
            w_sel_in = id;
        end
    end

    // A stage may load iff some stage from it to the end is empty, or the output drains;
    // this is the valid-chain advance rule written without a combinational chain.
    always_comb begin
        logic v_full;
        v_full = 1'b1;
        for (int k = 0; k < STAGES; k++) begin
            v_full = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                v_full = v_full & r_v[j];
            end
            w_load[k] = ~v_full | out_ready;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [PW-1:0] w_xe;
        logic [PW-1:0] w_ye;
        if (k == 0) begin : g_first
            assign w_xe         = {{WIDTH{a[WIDTH-1]}}, a};
            assign w_ye         = {{WIDTH{b[WIDTH-1]}}, b};
            assign w_in_v[k]    = in_valid;
            assign w_sel_src[k] = w_sel_in;
            assign w_res_new[k] = (w_sel_in == IDW'(k)) ? w_prod[k] : '0;
        end else begin : g_next
            assign w_xe         = {{WIDTH{r_p[k-1][WIDTH-1]}}, r_p[k-1][WIDTH-1:0]};
            assign w_ye         = {{WIDTH{r_p[k-1][PW-1]}}, r_p[k-1][PW-1:WIDTH]};
            assign w_in_v[k]    = r_v[k-1];
            assign w_sel_src[k] = r_sel[k-1];
            assign w_res_new[k] = (r_sel[k-1] == IDW'(k)) ? w_prod[k] : r_res[k-1];
        end
        // Sign-extended operands make the low 2*WIDTH bits the exact signed product.
        assign w_prod[k]   = w_xe * w_ye;
        assign w_v_next[k] = w_load[k] ? w_in_v[k] : r_v[k];
    end

    // Occupancy is the popcount of the next valid vector so it tracks r_v exactly.
    always_comb begin
        w_occ_next = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_occ_next = w_occ_next + OCW'(w_v_next[k]);
        end
    end

    // Pipeline state: stages load on advance, stalled stages hold everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v   <= '0;
            r_occ <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_p[k]   <= '0;
                r_res[k] <= '0;
                r_sel[k] <= '0;
            end
        end else begin
            r_v   <= w_v_next;
            r_occ <= w_occ_next;
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k] && w_in_v[k]) begin
                    r_p[k]   <= w_prod[k];
                    r_res[k] <= w_res_new[k];
                    r_sel[k] <= w_sel_src[k];
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_v[STAGES-1];
    assign c         = r_res[STAGES-1];
    assign occupancy = r_occ;

endmodule

// File: tb/tb_mult_signed_chain_pipe.sv
`timescale 1ns/1ps
// Self-checking bench: two depths of the chained multiplier against a transaction-level model.
module tb_mult_signed_chain_pipe;
    logic clk;
    logic rst;

    logic               iv2, rdy2, ov2, ordy2;
    logic signed [15:0] a2, b2;
    logic               id2;
    logic [31:0]        c2;
    logic [1:0]         occ2;

    logic               iv3, rdy3, ov3, ordy3;
    logic signed [15:0] a3, b3;
    logic [1:0]         id3;
    logic [31:0]        c3;
    logic [1:0]         occ3;

    int          n_checks;
    int          n_fail;
    int          cyc;
    int          n_out2;
    logic [31:0] q2[$];
    logic [31:0] q3[$];
    int          tq2[$];
    int          tq3[$];
    logic        hold2, hold3;
    logic [31:0] hc2, hc3;

    mult_signed_chain_pipe #(.WIDTH(16), .STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .a(a2), .b(b2), .id(id2),
        .out_valid(ov2), .out_ready(ordy2), .c(c2), .occupancy(occ2)
    );

    mult_signed_chain_pipe #(.WIDTH(16), .STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(rdy3), .a(a3), .b(b3), .id(id3),
        .out_valid(ov3), .out_ready(ordy3), .c(c3), .occupancy(occ3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: iterate the product chain with plain integer arithmetic.
    function automatic logic [31:0] ref_c(input logic signed [15:0] av, input logic signed [15:0] bv,
                                          input int idv, input int stages);
        longint      p;
        longint      x;
        longint      y;
        logic [31:0] pw;
        logic [31:0] r;
        int          sel;
        sel = (idv >= stages) ? stages - 1 : idv;
        r   = 32'h0;
        p   = longint'(av) * longint'(bv);
        for (int k = 0; k < stages; k++) begin
            if (k > 0) begin
                pw = p[31:0];
                x  = longint'($signed(pw[15:0]));
                y  = longint'($signed(pw[31:16]));
                p  = x * y;
            end
            if (k == sel) r = p[31:0];
        end
        return r;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Evaluate handshakes before the edge, then advance one clock.
    task automatic step();
        logic [31:0] e;
        logic        exp_ov;
        int          t;
        #1;
        if (!rst) begin
            check_eq("occ2", 64'(occ2), 64'(q2.size()));
            check_eq("rdy2", 64'(rdy2), 64'((q2.size() < 2) || ordy2));
            exp_ov = 1'b0;
            if (q2.size() > 0) exp_ov = (cyc - tq2[0] >= 2);
            check_eq("ov2", 64'(ov2), 64'(exp_ov));
            if (hold2) check_eq("hold2_c", 64'(c2), 64'(hc2));
            if (ov2 && ordy2 && q2.size() > 0) begin
                e = q2.pop_front();
                t = tq2.pop_front();
                check_eq("c2", 64'(c2), 64'(e));
                n_out2++;
            end
            hold2 = ov2 && !ordy2;
            hc2   = c2;
            if (iv2 && rdy2) begin
                q2.push_back(ref_c(a2, b2, int'(id2), 2));
                tq2.push_back(cyc);
            end

            check_eq("occ3", 64'(occ3), 64'(q3.size()));
            check_eq("rdy3", 64'(rdy3), 64'((q3.size() < 3) || ordy3));
            exp_ov = 1'b0;
            if (q3.size() > 0) exp_ov = (cyc - tq3[0] >= 3);
            check_eq("ov3", 64'(ov3), 64'(exp_ov));
            if (hold3) check_eq("hold3_c", 64'(c3), 64'(hc3));
            if (ov3 && ordy3 && q3.size() > 0) begin
                e = q3.pop_front();
                t = tq3.pop_front();
                check_eq("c3", 64'(c3), 64'(e));
            end
            hold3 = ov3 && !ordy3;
            hc3   = c3;
            if (iv3 && rdy3) begin
                q3.push_back(ref_c(a3, b3, int'(id3), 3));
                tq3.push_back(cyc);
            end
        end else begin
            hold2 = 1'b0;
            hold3 = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic directed(input int s, input logic signed [15:0] av, input logic signed [15:0] bv,
                            input logic [1:0] idv, input logic [31:0] expc, input string tag);
        int n;
        if (s == 2) begin
            a2 = av; b2 = bv; id2 = idv[0]; iv2 = 1'b1; ordy2 = 1'b1;
        end else begin
            a3 = av; b3 = bv; id3 = idv; iv3 = 1'b1; ordy3 = 1'b1;
        end
        step();
        iv2 = 1'b0;
        iv3 = 1'b0;
        n = 0;
        while ((((s == 2) ? ov2 : ov3) == 1'b0) && n < 10) begin
            step();
            n++;
        end
        check_eq({tag, "_c"}, 64'((s == 2) ? c2 : c3), 64'(expc));
        check_eq({tag, "_lat"}, 64'(n + 1), 64'(s));
        step();
    endtask

    task automatic drain(input string tag);
        int n;
        iv2 = 1'b0; iv3 = 1'b0; ordy2 = 1'b1; ordy3 = 1'b1;
        n = 0;
        while ((q2.size() > 0 || q3.size() > 0) && n < 20) begin
            step();
            n++;
        end
        check_eq({tag, "_q2"}, 64'(q2.size()), 64'd0);
        check_eq({tag, "_q3"}, 64'(q3.size()), 64'd0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; n_out2 = 0;
        hold2 = 1'b0; hold3 = 1'b0; hc2 = 32'h0; hc3 = 32'h0;
        rst = 1'b1;
        iv2 = 1'b0; ordy2 = 1'b1; a2 = 16'sd0; b2 = 16'sd0; id2 = 1'b0;
        iv3 = 1'b0; ordy3 = 1'b1; a3 = 16'sd0; b3 = 16'sd0; id3 = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ov2", 64'(ov2), 64'd0);
        check_eq("rst_c2", 64'(c2), 64'd0);
        check_eq("rst_occ2", 64'(occ2), 64'd0);
        check_eq("rst_rdy2", 64'(rdy2), 64'd1);
        check_eq("rst_ov3", 64'(ov3), 64'd0);
        check_eq("rst_rdy3", 64'(rdy3), 64'd1);
        rst = 1'b0;
        step();

        directed(2, 16'sd3, -16'sd5, 2'd0, 32'hFFFFFFF1, "tap0");
        directed(2, 16'sd3, -16'sd5, 2'd1, 32'h0000000F, "tap1");
        directed(2, -16'sd32768, -16'sd32768, 2'd0, 32'h40000000, "ext0");
        directed(2, -16'sd32768, -16'sd32768, 2'd1, 32'h00000000, "ext1");
        directed(3, 16'sd3, -16'sd5, 2'd3, 32'h00000000, "clamp3");
        directed(3, 16'sd3, -16'sd5, 2'd1, 32'h0000000F, "s3_tap1");
        directed(3, 16'sd1234, -16'sd77, 2'd3, ref_c(16'sd1234, -16'sd77, 2, 3), "clamp_eq2");

        // Back-to-back streaming; the model enforces exact latency and order.
        n_out2 = 0;
        ordy2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            iv2 = 1'b1; a2 = pick(); b2 = pick(); id2 = 1'($urandom);
            step();
        end
        drain("stream");
        check_eq("stream_count", 64'(n_out2), 64'd8);

        // Backpressure: pipeline fills and stalls with the output held.
        ordy2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv2 = 1'b1; a2 = pick(); b2 = pick(); id2 = 1'($urandom);
            step();
        end
        check_eq("bp_occ", 64'(occ2), 64'd2);
        check_eq("bp_rdy", 64'(rdy2), 64'd0);
        check_eq("bp_ov", 64'(ov2), 64'd1);
        drain("bp");

        // Reset with two transactions in flight.
        ordy2 = 1'b0;
        iv2 = 1'b1; a2 = 16'sd11; b2 = 16'sd13; id2 = 1'b0;
        step();
        step();
        iv2 = 1'b0;
        check_eq("mid_occ", 64'(occ2), 64'd2);
        rst = 1'b1;
        q2.delete(); tq2.delete(); hold2 = 1'b0;
        #1;
        check_eq("mid_rst_ov", 64'(ov2), 64'd0);
        check_eq("mid_rst_occ", 64'(occ2), 64'd0);
        check_eq("mid_rst_c", 64'(c2), 64'd0);
        check_eq("mid_rst_rdy", 64'(rdy2), 64'd1);
        step();
        step();
        rst = 1'b0;
        ordy2 = 1'b1;
        repeat (4) step();
        directed(2, -16'sd7, 16'sd9, 2'd0, 32'hFFFFFFC1, "post_rst");

        // Randomized traffic with random backpressure on both depths.
        for (int i = 0; i < 400; i++) begin
            iv2 = ($urandom_range(0, 3) != 0); ordy2 = ($urandom_range(0, 3) != 0);
            a2 = pick(); b2 = pick(); id2 = 1'($urandom_range(0, 1));
            iv3 = ($urandom_range(0, 3) != 0); ordy3 = ($urandom_range(0, 3) != 0);
            a3 = pick(); b3 = pick(); id3 = 2'($urandom_range(0, 3));
            step();
        end
        drain("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
